imgmem_fill_scheduler: RTL and testbench
========================================

// Module: imgmem_fill_scheduler
// PURPOSE
//  Shares the single-port 640x480x8 colour-index image memory between VGA scanout and game logic.
//  Accepts rectangle-fill requests (tile/board cell redraws) over valid/ready.
//  Issues pixel writes only on cycles where scanout is in blanking (iBLANK_n=0); scanout always wins.
//  Sits between the sync generator / address generator and the image memory port.
// PARAMETERS
//  H_RES   640  active pixels per line; row stride of memory
//  V_RES   480  active lines
//  ADDR_W  19   image memory address width
//  IDX_W   8    colour-index width
// PORTS
//  iVGA_CLK     in   1       sole clock; all logic on posedge
//  iRST         in   1       synchronous, active-high reset
//  iBLANK_n     in   1       1 = active video (scanout owns memory), 0 = blanking
//  iSCAN_ADDR   in   ADDR_W  scanout read address
//  iREQ_VALID   in   1       fill request valid
//  oREQ_READY   out  1       block can accept a request
//  iREQ_X       in   10      rectangle left column
//  iREQ_Y       in   9       rectangle top row
//  iREQ_W       in   10      width in pixels
//  iREQ_H       in   9       height in pixels
//  iREQ_COLOR   in   IDX_W   fill colour index
//  oMEM_ADDR    out  ADDR_W  image memory address
//  oMEM_WE      out  1       image memory write enable
//  oMEM_WDATA   out  IDX_W   image memory write data
//  oBUSY        out  1       fill in progress
//  oDONE        out  1       one-cycle pulse: request retired
// BEHAVIOUR
//  Reset: state IDLE; oREQ_READY=1, oMEM_WE=0, oBUSY=0, oDONE=0, oMEM_WDATA=0; oMEM_ADDR follows mux.
//  FSM: IDLE -> FILL on accept (iREQ_VALID & oREQ_READY); FILL -> DONE after last pixel written;
//   IDLE -> DONE directly if clipped rectangle empty; DONE -> IDLE next cycle (oDONE=1 in DONE).
//  oREQ_READY = (state==IDLE); request fields latched on accept; inputs ignored otherwise.
//  Clipping at accept: empty if W==0, H==0, X>=H_RES or Y>=V_RES;
//   x_last = min(X+W, H_RES)-1, y_last = min(Y+H, V_RES)-1; sums in 11/10 bits, no wrap.
//  Address: row_base = Y*H_RES computed once at accept (multi-cycle allowed, but FILL issues no
//   write until valid); pixel addr = row_base + col; next row: row_base += H_RES, col = X.
//  Scan order: raster (col increments, then row). Last pixel = (x_last, y_last) -> DONE.
//  Arbitration, combinational on iBLANK_n:
//   iBLANK_n=1: oMEM_ADDR=iSCAN_ADDR, oMEM_WE=0, fill counters hold.
//   iBLANK_n=0 & FILL: oMEM_ADDR=fill addr, oMEM_WE=1, oMEM_WDATA=latched colour; counters advance.
//   iBLANK_n=0 & not FILL: oMEM_ADDR=iSCAN_ADDR, oMEM_WE=0.
//  Scanout address path adds zero latency; exactly one write per blanking cycle while FILL.
//  Blanking edge mid-row: fill stalls and resumes at the same pixel; no pixel skipped or repeated.
//  oBUSY = (state != IDLE).
//  Reset mid-fill: next cycle oMEM_WE=0, state IDLE, request discarded, no oDONE.
//  Throughput: W*H writes for an unclipped in-range rect; cycles = write cycles + stalls + 2.
// STRUCTURE
//  Package imgmem_pkg: H_RES, V_RES, ADDR_W, IDX_W, fill FSM state enum (IDLE/FILL/DONE).
//  Sub-module imgmem_rect_addr_gen: latched bounds, col/row counters, row_base accumulator,
//   outputs pixel address + last flag, advances on step input.
//  Top holds FSM, request handshake, clipping and the arbitration mux.
// TESTING
//  Fill X=10,Y=2,W=3,H=2,C=0x1F with iBLANK_n=0 -> WE on addrs 1290,1291,1292,1930,1931,1932; oDONE once.
//  Same request, iBLANK_n toggled 1/0 every 2 cycles -> same 6 writes, none while iBLANK_n=1; mem addr = iSCAN_ADDR then.
//  X=638,Y=479,W=5,H=4 -> clipped to addrs 307198,307199 only; oDONE.
//  W=0 or X=700 -> no WE; oDONE 1 cycle after accept; oREQ_READY back high next cycle.
//  iRST pulse after 3 of 6 writes -> WE=0 next cycle, oBUSY=0, no oDONE; new request accepted normally.
//  Back-to-back requests with iREQ_VALID held -> second accepted only after DONE; fields change mid-fill ignored.

Source files
------------

// File: rtl/imgmem_fill_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imgmem_pkg
// Description : Shared constants and fill-FSM state type for the image-memory
//               fill scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package imgmem_pkg;
    localparam int H_RES  = 640;
    localparam int V_RES  = 480;
    localparam int ADDR_W = 19;
    localparam int IDX_W  = 8;
    localparam int XW     = 10;
    localparam int YW     = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fill_state_t;
endpackage
`default_nettype wire

// File: rtl/imgmem_fill_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : imgmem_fill_scheduler_if
// Description : Fill-request handshake plus image-memory write port bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface imgmem_fill_scheduler_if;
    import imgmem_pkg::*;

    logic              iREQ_VALID;
    logic              oREQ_READY;
    logic [XW-1:0]     iREQ_X;
    logic [YW-1:0]     iREQ_Y;
    logic [XW-1:0]     iREQ_W;
    logic [YW-1:0]     iREQ_H;
    logic [IDX_W-1:0]  iREQ_COLOR;
    logic [ADDR_W-1:0] oMEM_ADDR;
    logic              oMEM_WE;
    logic [IDX_W-1:0]  oMEM_WDATA;

    modport slave (
        input  iREQ_VALID, iREQ_X, iREQ_Y, iREQ_W, iREQ_H, iREQ_COLOR,
        output oREQ_READY, oMEM_ADDR, oMEM_WE, oMEM_WDATA
    );

    modport master (
        output iREQ_VALID, iREQ_X, iREQ_Y, iREQ_W, iREQ_H, iREQ_COLOR,
        input  oREQ_READY, oMEM_ADDR, oMEM_WE, oMEM_WDATA
    );
endinterface
`default_nettype wire

// File: rtl/imgmem_rect_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : imgmem_rect_addr_gen
// Description : Raster walker over a clipped rectangle; yields pixel address
//               and a last-pixel flag, advancing one pixel per step.
// Revision    : 1.0 - initial release
// ============================================================================
module imgmem_rect_addr_gen
    import imgmem_pkg::*;
(
    input  wire logic              iVGA_CLK,
    input  wire logic              iRST,
    input  wire logic              iLOAD,
    input  wire logic              iSTEP,
    input  wire logic [XW-1:0]     iX0,
    input  wire logic [XW-1:0]     iX_LAST,
    input  wire logic [YW-1:0]     iY0,
    input  wire logic [YW-1:0]     iY_LAST,
    output logic      [ADDR_W-1:0] oADDR,
    output logic                   oLAST
);
    localparam logic [ADDR_W-1:0] C_STRIDE = ADDR_W'(H_RES);

    logic [XW-1:0]     r_x0;
    logic [XW-1:0]     r_x_last;
    logic [YW-1:0]     r_y_last;
    logic [XW-1:0]     r_col;
    logic [YW-1:0]     r_row;
    logic [ADDR_W-1:0] r_row_base;

    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            r_x0       <= '0;
            r_x_last   <= '0;
            r_y_last   <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_row_base <= '0;
        end else if (iLOAD) begin
            r_x0       <= iX0;
            r_x_last   <= iX_LAST;
            r_y_last   <= iY_LAST;
            r_col      <= iX0;
            r_row      <= iY0;
            r_row_base <= ADDR_W'(iY0) * C_STRIDE;
        end else if (iSTEP) begin
            // End of a row: wrap column and move the base down one stride.
            if (r_col == r_x_last) begin
                r_col      <= r_x0;
                r_row      <= r_row + 1'b1;
                r_row_base <= r_row_base + C_STRIDE;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    assign oADDR = r_row_base + ADDR_W'(r_col);
    assign oLAST = (r_col == r_x_last) && (r_row == r_y_last);
endmodule
`default_nettype wire

// File: rtl/imgmem_fill_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : imgmem_fill_scheduler
// Description : Rectangle-fill engine sharing the image memory with scanout;
//               writes only during blanking, scanout always wins.
// Revision    : 1.0 - initial release
// ============================================================================
module imgmem_fill_scheduler
    import imgmem_pkg::*;
(
    input  wire logic              iVGA_CLK,
    input  wire logic              iRST,
    input  wire logic              iBLANK_n,
    input  wire logic [ADDR_W-1:0] iSCAN_ADDR,
    imgmem_fill_scheduler_if.slave bus,
    output logic                   oBUSY,
    output logic                   oDONE
);
    localparam logic [XW:0] C_HRES = (XW+1)'(H_RES);
    localparam logic [YW:0] C_VRES = (YW+1)'(V_RES);

    fill_state_t       r_state;
    logic [IDX_W-1:0]  r_color;

    logic [XW:0]       w_xe;
    logic [XW:0]       w_xlim;
    logic [YW:0]       w_ye;
    logic [YW:0]       w_ylim;
    logic [XW-1:0]     w_x_last;
    logic [YW-1:0]     w_y_last;
    logic              w_empty;
    logic              w_accept;
    logic              w_load;
    logic              w_step;
    logic              w_last;
    logic [ADDR_W-1:0] w_fill_addr;

    // Clip against the visible area; sums are one bit wider so they never wrap.
    assign w_xe     = {1'b0, bus.iREQ_X} + {1'b0, bus.iREQ_W};
    assign w_ye     = {1'b0, bus.iREQ_Y} + {1'b0, bus.iREQ_H};
    assign w_xlim   = (w_xe > C_HRES) ? C_HRES : w_xe;
    assign w_ylim   = (w_ye > C_VRES) ? C_VRES : w_ye;
    assign w_x_last = XW'(w_xlim - 1'b1);
    assign w_y_last = YW'(w_ylim - 1'b1);
    assign w_empty  = (bus.iREQ_W == '0) || (bus.iREQ_H == '0) ||
                      ({1'b0, bus.iREQ_X} >= C_HRES) ||
                      ({1'b0, bus.iREQ_Y} >= C_VRES);

    assign w_accept = bus.iREQ_VALID && (r_state == IDLE);
    assign w_load   = w_accept && !w_empty;
    assign w_step   = (r_state == FILL) && !iBLANK_n;

    imgmem_rect_addr_gen u_addr_gen (
        .iVGA_CLK (iVGA_CLK),
        .iRST     (iRST),
        .iLOAD    (w_load),
        .iSTEP    (w_step),
        .iX0      (bus.iREQ_X),
        .iX_LAST  (w_x_last),
        .iY0      (bus.iREQ_Y),
        .iY_LAST  (w_y_last),
        .oADDR    (w_fill_addr),
        .oLAST    (w_last)
    );

    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            r_state <= IDLE;
            r_color <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_color <= bus.iREQ_COLOR;
                        r_state <= w_empty ? DONE : FILL;
                    end
                end
                FILL: begin
                    if (w_step && w_last) begin
                        r_state <= DONE;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.oREQ_READY = (r_state == IDLE);
    assign bus.oMEM_WE    = w_step;
    assign bus.oMEM_ADDR  = w_step ? w_fill_addr : iSCAN_ADDR;
    assign bus.oMEM_WDATA = r_color;
    assign oBUSY          = (r_state != IDLE);
    assign oDONE          = (r_state == DONE);
endmodule
`default_nettype wire

// File: tb/tb_imgmem_fill_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_imgmem_fill_scheduler
// Description : Directed self-checking bench for imgmem_fill_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imgmem_fill_scheduler;
    import imgmem_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              blank_n = 1'b0;
    logic [ADDR_W-1:0] scan_addr = '0;
    logic              busy;
    logic              done;

    imgmem_fill_scheduler_if bus ();

    imgmem_fill_scheduler dut (
        .iVGA_CLK   (clk),
        .iRST       (rst),
        .iBLANK_n   (blank_n),
        .iSCAN_ADDR (scan_addr),
        .bus        (bus),
        .oBUSY      (busy),
        .oDONE      (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [9:0] ax, aw, bx, bw;
    logic [8:0] ay, ah, by, bh;
    logic [7:0] ac, bc;

    logic [ADDR_W-1:0] wq_addr[$];
    logic [7:0]        wq_data[$];
    int                exp_a[$];
    logic [7:0]        exp_d[$];
    bit   [127:0]      lg_we, lg_ready, lg_busy, lg_done;
    int                done_cnt, done_idx, accepts;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_writes(input string tag);
        chk({tag, "_count"}, wq_addr.size(), exp_a.size());
        for (int k = 0; k < exp_a.size() && k < wq_addr.size(); k++) begin
            chk($sformatf("%s_addr%0d", tag, k), 32'(wq_addr[k]), exp_a[k]);
            chk($sformatf("%s_data%0d", tag, k), 32'(wq_data[k]), 32'(exp_d[k]));
        end
    endtask

    // Entered at posedge+1; returns at posedge+1. Index i = cycles after the
    // cycle in which the first request is presented.
    task automatic run(input int n_req, input int mode, input int rst_at, input int bound);
        bit fin;
        int i;
        wq_addr.delete(); wq_data.delete();
        lg_we = '0; lg_ready = '0; lg_busy = '0; lg_done = '0;
        done_cnt = 0; done_idx = -1; accepts = 0;
        fin = 1'b0; i = 0;
        while (!fin) begin
            rst       = (i == rst_at);
            blank_n   = (mode == 1) ? (((i >> 1) & 1) == 1) : 1'b0;
            scan_addr = ADDR_W'(1000 + 7 * i);
            bus.iREQ_VALID = (accepts < n_req);
            bus.iREQ_X     = (accepts == 0) ? ax : bx;
            bus.iREQ_Y     = (accepts == 0) ? ay : by;
            bus.iREQ_W     = (accepts == 0) ? aw : bw;
            bus.iREQ_H     = (accepts == 0) ? ah : bh;
            bus.iREQ_COLOR = (accepts == 0) ? ac : bc;
            #1;
            lg_we[i] = bus.oMEM_WE; lg_ready[i] = bus.oREQ_READY;
            lg_busy[i] = busy;      lg_done[i] = done;
            if (bus.oMEM_WE) begin
                wq_addr.push_back(bus.oMEM_ADDR);
                wq_data.push_back(bus.oMEM_WDATA);
            end
            if (blank_n) begin
                chk("scan_addr", 32'(bus.oMEM_ADDR), 32'(scan_addr));
                chk("scan_we", 32'(bus.oMEM_WE), 0);
            end
            if (bus.iREQ_VALID && bus.oREQ_READY) accepts++;
            if (done) begin done_cnt++; done_idx = i; end
            @(posedge clk); #1;
            if (rst_at >= 0) fin = (i == rst_at + 2);
            else             fin = (done_cnt == n_req) && (i == done_idx + 1);
            if (!fin && i >= bound) begin
                n_checks++; n_errors++;
                $error("FAIL timeout observed=%0d cycles expected=done", i);
                fin = 1'b1;
            end
            i++;
        end
        rst = 1'b0; bus.iREQ_VALID = 1'b0; blank_n = 1'b1;
    endtask

    task automatic set_a(input int x, input int y, input int w, input int h, input int c);
        ax = 10'(x); ay = 9'(y); aw = 10'(w); ah = 9'(h); ac = 8'(c);
    endtask

    task automatic exp_rect1(input logic [7:0] c);
        exp_a = '{1290, 1291, 1292, 1930, 1931, 1932};
        exp_d.delete();
        for (int k = 0; k < 6; k++) exp_d.push_back(c);
    endtask

    initial begin
        bus.iREQ_VALID = 1'b0; bus.iREQ_X = '0; bus.iREQ_Y = '0;
        bus.iREQ_W = '0; bus.iREQ_H = '0; bus.iREQ_COLOR = '0;
        bx = '0; by = '0; bw = '0; bh = '0; bc = '0;
        set_a(0, 0, 0, 0, 0);

        // Reset state
        repeat (2) @(posedge clk);
        #1 scan_addr = 19'd123;
        #1;
        chk("rst_ready", 32'(bus.oREQ_READY), 1);
        chk("rst_we",    32'(bus.oMEM_WE), 0);
        chk("rst_busy",  32'(busy), 0);
        chk("rst_done",  32'(done), 0);
        chk("rst_wdata", 32'(bus.oMEM_WDATA), 0);
        chk("rst_addr",  32'(bus.oMEM_ADDR), 123);
        @(posedge clk); #1;

        // Basic fill, blanking throughout
        set_a(10, 2, 3, 2, 8'h1F);
        run(1, 0, -1, 60);
        exp_rect1(8'h1F);
        chk_writes("fill");
        chk("fill_done_cnt", done_cnt, 1);
        chk("fill_done_idx", done_idx, 7);
        chk("fill_busy1",    32'(lg_busy[1]), 1);
        chk("fill_ready1",   32'(lg_ready[1]), 0);
        chk("fill_ready8",   32'(lg_ready[8]), 1);
        chk("fill_busy8",    32'(lg_busy[8]), 0);

        // Same fill with blanking toggling every two cycles
        run(1, 1, -1, 60);
        chk_writes("tog");
        chk("tog_done_cnt", done_cnt, 1);
        chk("tog_done_idx", done_idx, 13);

        // Clipped at bottom-right corner
        set_a(638, 479, 5, 4, 8'h2A);
        run(1, 0, -1, 60);
        exp_a = '{307198, 307199};
        exp_d = '{8'h2A, 8'h2A};
        chk_writes("clip");
        chk("clip_done_idx", done_idx, 3);

        // Empty rectangles
        exp_a.delete(); exp_d.delete();
        set_a(5, 5, 0, 3, 8'h07);
        run(1, 0, -1, 30);
        chk_writes("w0");
        chk("w0_done_idx", done_idx, 1);
        chk("w0_ready1",   32'(lg_ready[1]), 0);
        chk("w0_ready2",   32'(lg_ready[2]), 1);
        set_a(700, 5, 4, 3, 8'h07);
        run(1, 0, -1, 30);
        chk_writes("x700");
        chk("x700_done_idx", done_idx, 1);
        chk("x700_ready2",   32'(lg_ready[2]), 1);

        // Reset after three writes
        set_a(10, 2, 3, 2, 8'h1F);
        run(1, 0, 3, 30);
        exp_a = '{1290, 1291, 1292};
        exp_d = '{8'h1F, 8'h1F, 8'h1F};
        chk_writes("rstmid");
        chk("rstmid_we4",    32'(lg_we[4]), 0);
        chk("rstmid_busy4",  32'(lg_busy[4]), 0);
        chk("rstmid_ready4", 32'(lg_ready[4]), 1);
        chk("rstmid_done",   done_cnt, 0);
        run(1, 0, -1, 60);
        exp_rect1(8'h1F);
        chk_writes("after_rst");
        chk("after_rst_done_idx", done_idx, 7);

        // Back-to-back, valid held, fields changed mid-fill
        bx = 10'd0; by = 9'd0; bw = 10'd2; bh = 9'd1; bc = 8'h05;
        run(2, 0, -1, 80);
        exp_rect1(8'h1F);
        exp_a.push_back(0); exp_a.push_back(1);
        exp_d.push_back(8'h05); exp_d.push_back(8'h05);
        chk_writes("b2b");
        chk("b2b_done_cnt", done_cnt, 2);
        chk("b2b_done7",    32'(lg_done[7]), 1);
        chk("b2b_ready8",   32'(lg_ready[8]), 1);
        chk("b2b_done_idx", done_idx, 11);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
